// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin ALU/load writeback arbitration,
// one-cycle registered write, and a pending-write scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PC_ADDR    = 15,
  parameter bit          DROP_PC_WR = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [ADDR_W-1:0] r2_addr_i,
  output logic              r1_busy_o,
  output logic              r2_busy_o,
  output logic              stall_o,
  output logic              rf_wr_en_o,
  output logic [ADDR_W-1:0] rf_wr_addr_o,
  output logic [DATA_W-1:0] rf_data_o
);

  localparam int unsigned       NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_ADDR);

  typedef enum logic {PRI_ALU = 1'b0, PRI_MEM = 1'b1} pri_e;

  pri_e              state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic              alu_grant, mem_grant;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= PRI_ALU;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  // Arbitration, next priority state and registered write staging.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    alu_grant  = 1'b0;
    mem_grant  = 1'b0;
    grant_addr = alu_addr_i;
    grant_data = alu_data_i;

    unique case (state_q)
      PRI_ALU: alu_grant = alu_valid_i;
      PRI_MEM: alu_grant = alu_valid_i & ~mem_valid_i;
      default: alu_grant = 1'b0;
    endcase
    mem_grant = mem_valid_i & ~alu_grant;

    if (mem_grant) begin
      grant_addr = mem_addr_i;
      grant_data = mem_data_i;
    end

    if (alu_grant) begin
      state_d = PRI_MEM;
    end else if (mem_grant) begin
      state_d = PRI_ALU;
    end

    if (alu_grant | mem_grant) begin
      wr_addr_d = grant_addr;
      wr_data_d = grant_data;
      wr_en_d   = ~(DROP_PC_WR && (grant_addr == PC_A));
    end
  end

  // Scoreboard: a new issue overrides a same-cycle retirement of that register.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_q) begin
      pending_d[wr_addr_q] = 1'b0;
    end
    if (issue_en_i && (issue_addr_i != PC_A)) begin
      pending_d[issue_addr_i] = 1'b1;
    end
    pending_d[PC_A] = 1'b0;
  end

  assign alu_ready_o  = alu_grant;
  assign mem_ready_o  = mem_grant;
  assign r1_busy_o    = (r1_addr_i != PC_A) & pending_q[r1_addr_i];
  assign r2_busy_o    = (r2_addr_i != PC_A) & pending_q[r2_addr_i];
  assign stall_o      = r1_busy_o | r2_busy_o;
  assign rf_wr_en_o   = wr_en_q;
  assign rf_wr_addr_o = wr_addr_q;
  assign rf_data_o    = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference arbiter/scoreboard model
// queues each cycle's expected write and checks it one cycle later.
module tb_regfile_wb_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] PC = 4'd15;

  typedef struct {
    logic          en;
    logic          chk;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0, mem_valid = 1'b0, issue_en = 1'b0;
  logic [AW-1:0] alu_addr = '0, mem_addr = '0, issue_addr = '0, r1_addr = '0, r2_addr = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic          alu_ready, mem_ready, r1_busy, r2_busy, stall, rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_data;

  int vectors = 0;
  int miscompares = 0;

  wr_item_t      sb_q[$];
  wr_item_t      cur, nxt;
  logic          m_pri_mem;
  logic [15:0]   m_pend;
  logic [AW-1:0] m_last_a;
  logic [DW-1:0] m_last_d;
  logic          m_known;
  logic          alu_fire = 1'b0, mem_fire = 1'b0;

  regfile_wb_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .mem_valid_i(mem_valid), .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_ready_o(mem_ready),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr),
    .r1_addr_i(r1_addr), .r2_addr_i(r2_addr),
    .r1_busy_o(r1_busy), .r2_busy_o(r2_busy), .stall_o(stall),
    .rf_wr_en_o(rf_wr_en), .rf_wr_addr_o(rf_wr_addr), .rf_data_o(rf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model, evaluated mid-cycle while inputs and registered outputs are stable.
  always @(negedge clk) begin
    logic ag, mg, drop, b1, b2;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    if (rst) begin
      sb_q.delete();
      sb_q.push_back('{en: 1'b0, chk: 1'b1, addr: '0, data: '0});
      m_pri_mem = 1'b0;
      m_pend    = '0;
      m_last_a  = '0;
      m_last_d  = '0;
      m_known   = 1'b1;
      alu_fire  = 1'b0;
      mem_fire  = 1'b0;
      check("rst_wr_en", 64'(rf_wr_en), 64'd0);
      check("rst_wr_addr", 64'(rf_wr_addr), 64'd0);
      check("rst_data", 64'(rf_data), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
    end else begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
        cur = '{en: 1'b0, chk: 1'b0, addr: '0, data: '0};
      end else begin
        cur = sb_q.pop_front();
      end
      check("wr_en", 64'(rf_wr_en), 64'(cur.en));
      if (cur.chk) begin
        check("wr_addr", 64'(rf_wr_addr), 64'(cur.addr));
        check("wr_data", 64'(rf_data), 64'(cur.data));
      end

      b1 = (r1_addr != PC) && m_pend[r1_addr];
      b2 = (r2_addr != PC) && m_pend[r2_addr];
      check("r1_busy", 64'(r1_busy), 64'(b1));
      check("r2_busy", 64'(r2_busy), 64'(b2));
      check("stall", 64'(stall), 64'(b1 | b2));

      ag = alu_valid && (!mem_valid || !m_pri_mem);
      mg = mem_valid && !ag;
      check("alu_ready", 64'(alu_ready), 64'(ag));
      check("mem_ready", 64'(mem_ready), 64'(mg));

      if (ag || mg) begin
        ga   = ag ? alu_addr : mem_addr;
        gd   = ag ? alu_data : mem_data;
        drop = (ga == PC);
        nxt  = '{en: !drop, chk: !drop, addr: ga, data: gd};
        m_known  = !drop;
        m_last_a = ga;
        m_last_d = gd;
        m_pri_mem = ag;
      end else begin
        nxt = '{en: 1'b0, chk: m_known, addr: m_last_a, data: m_last_d};
      end
      sb_q.push_back(nxt);

      if (cur.en) m_pend[cur.addr] = 1'b0;
      if (issue_en && issue_addr != PC) m_pend[issue_addr] = 1'b1;

      alu_fire = alu_valid & alu_ready;
      mem_fire = mem_valid & mem_ready;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    issue_en  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;

    // Reset landing on a cycle with a live registered write and a pending entry.
    issue_en = 1'b1; issue_addr = 4'd9;
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 32'h1234_5678;
    tick();
    issue_en = 1'b0; alu_valid = 1'b0; r1_addr = 4'd9;
    check("pre_rst_wr_en", 64'(rf_wr_en), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_wr_en", 64'(rf_wr_en), 64'd0);
    check("async_wr_addr", 64'(rf_wr_addr), 64'd0);
    check("async_data", 64'(rf_data), 64'd0);
    check("async_r1_busy", 64'(r1_busy), 64'd0);
    tick();
    rst = 1'b0;

    // Single ALU write.
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEAD_BEEF;
    #1 check("t2_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check("t2_wr_en", 64'(rf_wr_en), 64'd1);
    check("t2_wr_addr", 64'(rf_wr_addr), 64'd3);
    check("t2_data", 64'(rf_data), 64'hDEAD_BEEF);

    // Both valid from reset: strict alternation starting with ALU.
    do_reset();
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'hA1A1_0001;
    mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'hB2B2_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_alu_ready", 64'(alu_ready), 64'((i % 2) == 0));
      check("t3_mem_ready", 64'(mem_ready), 64'((i % 2) == 1));
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();

    // RAW stall on r5 until its write has been presented to the RF.
    issue_en = 1'b1; issue_addr = 4'd5;
    tick();
    issue_en = 1'b0; r1_addr = 4'd5;
    #1 check("t4_busy_set", 64'(stall), 64'd1);
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h0000_0055;
    tick();
    alu_valid = 1'b0;
    check("t4_busy_during_wr", 64'(r1_busy), 64'd1);
    tick();
    check("t4_busy_cleared", 64'(r1_busy), 64'd0);

    // Issue colliding with a retirement of the same register.
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h0000_0077;
    tick();
    alu_valid = 1'b0;
    issue_en = 1'b1; issue_addr = 4'd7;
    tick();
    issue_en = 1'b0; r2_addr = 4'd7;
    #1 check("t5_r2_busy", 64'(r2_busy), 64'd1);

    // PC write is handshaken but dropped; PC never becomes pending.
    mem_valid = 1'b1; mem_addr = 4'd15; mem_data = 32'h40;
    #1 check("t6_mem_ready", 64'(mem_ready), 64'd1);
    tick();
    mem_valid = 1'b0;
    check("t6_wr_en", 64'(rf_wr_en), 64'd0);
    issue_en = 1'b1; issue_addr = 4'd15;
    tick();
    issue_en = 1'b0; r1_addr = 4'd15;
    #1 check("t6_pc_busy", 64'(r1_busy), 64'd0);

    // Random traffic; requesters hold until accepted.
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!alu_valid || alu_fire) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_addr  = AW'($urandom_range(0, 15));
        alu_data  = $urandom;
      end
      if (!mem_valid || mem_fire) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_addr  = AW'($urandom_range(0, 15));
        mem_data  = $urandom;
      end
      issue_en   = ($urandom_range(0, 3) == 0);
      issue_addr = AW'($urandom_range(0, 15));
      r1_addr    = AW'($urandom_range(0, 15));
      r2_addr    = AW'($urandom_range(0, 15));
    end
    alu_valid = 1'b0; mem_valid = 1'b0; issue_en = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
